// File: rtl/controle_envase_pkg.sv
// rtl/controle_envase_pkg.sv - shared types, defaults and output decode for the bottle-filling controller
// Contents: state encoding (3-bit), default TARGET / FILL_TIMEOUT, actuator bundle and its Moore decode.
package controle_envase_pkg;

  localparam int DEFAULT_TARGET       = 12;
  localparam int DEFAULT_FILL_TIMEOUT = 200;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MOVE  = 3'd1,
    ST_FILL  = 3'd2,
    ST_CAP   = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5,
    ST_FAULT = 3'd6
  } state_t;

  typedef struct packed {
    logic conveyor_on;
    logic valve_open;
    logic capper_go;
    logic batch_done;
    logic fault;
  } act_t;

  // Moore decode; the FSM registers this for the state it is entering so the
  // outputs change on the same edge as the state.
  function automatic act_t decode_outputs(state_t s);
    act_t a;
    a = '0;
    case (s)
      ST_MOVE:  a.conveyor_on = 1'b1;
      ST_FILL:  a.valve_open  = 1'b1;
      ST_CAP:   a.capper_go   = 1'b1;
      ST_DONE:  a.batch_done  = 1'b1;
      ST_FAULT: a.fault       = 1'b1;
      default:  a = '0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/controle_envase_if.sv
// rtl/controle_envase_if.sv - station sensor/actuator bundle for one filling line
// Signals: start, stop, bottle_present, level_full, box_ack, fault_clr (sensors/operator, into the controller);
//          conveyor_on, valve_open, capper_go, batch_done, fault, bottle_count[7:0] (out of the controller).
// Modports: master = station side (drives sensors), slave = controller side.
interface controle_envase_if;
  logic       start;
  logic       stop;
  logic       bottle_present;
  logic       level_full;
  logic       box_ack;
  logic       fault_clr;
  logic       conveyor_on;
  logic       valve_open;
  logic       capper_go;
  logic       batch_done;
  logic       fault;
  logic [7:0] bottle_count;

  modport master (
    output start, stop, bottle_present, level_full, box_ack, fault_clr,
    input  conveyor_on, valve_open, capper_go, batch_done, fault, bottle_count
  );

  modport slave (
    input  start, stop, bottle_present, level_full, box_ack, fault_clr,
    output conveyor_on, valve_open, capper_go, batch_done, fault, bottle_count
  );
endinterface

// File: rtl/comparador_8bit.sv
// rtl/comparador_8bit.sv - 8-bit equality comparator
// Ports: a[7:0], b[7:0] operands; eq = 1 when a equals b.
module comparador_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       eq
);
  assign eq = (a == b);
endmodule

// File: rtl/controle_envase.sv
// rtl/controle_envase.sv - bottle-filling station sequencer: conveyor, fill valve, capper, batch count
// Ports: clk, rst_n (async active-low); bus (controle_envase_if.slave) carrying sensors in and actuators out.
// Parameters: TARGET bottles per batch (1..255), FILL_TIMEOUT max FILL cycles (2..255).
module controle_envase
  import controle_envase_pkg::*;
#(
  parameter int TARGET       = DEFAULT_TARGET,
  parameter int FILL_TIMEOUT = DEFAULT_FILL_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  controle_envase_if.slave   bus
);

  localparam logic [7:0] TARGET_B     = 8'(TARGET);
  localparam logic [7:0] TIMEOUT_LAST = 8'(FILL_TIMEOUT - 1);

  state_t     state;
  state_t     nxt;
  act_t       act;
  logic [7:0] count;
  logic [7:0] timer;
  logic       batch_eq;
  logic       timeout_eq;

  comparador_8bit u_cmp_batch (
    .a  (count),
    .b  (TARGET_B),
    .eq (batch_eq)
  );

  // timer holds (cycles already spent in FILL); hitting FILL_TIMEOUT-1 means
  // the current cycle is the last one allowed.
  comparador_8bit u_cmp_timeout (
    .a  (timer),
    .b  (TIMEOUT_LAST),
    .eq (timeout_eq)
  );

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (bus.start && !bus.stop) nxt = ST_MOVE;
      ST_MOVE: begin
        if (bus.stop)                nxt = ST_IDLE;
        else if (bus.bottle_present) nxt = ST_FILL;
      end
      ST_FILL: begin
        if (bus.level_full)  nxt = ST_CAP;
        else if (timeout_eq) nxt = ST_FAULT;
      end
      ST_CAP:   nxt = ST_CHECK;
      // count already includes the bottle just capped
      ST_CHECK: begin
        if (batch_eq)      nxt = ST_DONE;
        else if (bus.stop) nxt = ST_IDLE;
        else               nxt = ST_MOVE;
      end
      ST_DONE:  if (bus.box_ack)   nxt = ST_IDLE;
      ST_FAULT: if (bus.fault_clr) nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      act   <= '0;
    end else begin
      state <= nxt;
      act   <= decode_outputs(nxt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (state == ST_CAP) begin
      count <= count + 8'd1;
    end else if (state == ST_DONE && bus.box_ack) begin
      count <= 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= 8'd0;
    end else if (state == ST_MOVE && !bus.stop && bus.bottle_present) begin
      timer <= 8'd0;
    end else if (state == ST_FILL) begin
      timer <= timer + 8'd1;
    end
  end

  assign bus.conveyor_on  = act.conveyor_on;
  assign bus.valve_open   = act.valve_open;
  assign bus.capper_go    = act.capper_go;
  assign bus.batch_done   = act.batch_done;
  assign bus.fault        = act.fault;
  assign bus.bottle_count = count;

endmodule

// File: tb/tb_controle_envase.sv
// tb/tb_controle_envase.sv - self-checking bench for controle_envase (TARGET=3, FILL_TIMEOUT=5)
module tb_controle_envase;

  localparam int TGT = 3;
  localparam int FT  = 5;

  localparam int P_IDLE  = 0;
  localparam int P_MOVE  = 1;
  localparam int P_FILL  = 2;
  localparam int P_CAP   = 3;
  localparam int P_CHECK = 4;
  localparam int P_DONE  = 5;
  localparam int P_FAULT = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  controle_envase_if bus();

  controle_envase #(.TARGET(TGT), .FILL_TIMEOUT(FT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [4:0] outs;
  assign outs = {bus.conveyor_on, bus.valve_open, bus.capper_go, bus.batch_done, bus.fault};

  int n_cmp = 0;
  int n_bad = 0;

  int m_phase = P_IDLE;
  int m_fill  = 0;
  int m_count = 0;

  int caps;
  int vcnt;
  int len;
  int gap;
  int valve_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] exp_outs(input int ph);
    case (ph)
      P_MOVE:  return 5'b10000;
      P_FILL:  return 5'b01000;
      P_CAP:   return 5'b00100;
      P_DONE:  return 5'b00010;
      P_FAULT: return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  // One clock of the station as described by the operating rules, applied to
  // the inputs currently on the bus.
  task automatic model_step();
    case (m_phase)
      P_IDLE: if (bus.start && !bus.stop) m_phase = P_MOVE;
      P_MOVE: begin
        if (bus.stop) m_phase = P_IDLE;
        else if (bus.bottle_present) begin
          m_phase = P_FILL;
          m_fill  = 0;
        end
      end
      P_FILL: begin
        m_fill++;
        if (bus.level_full)  m_phase = P_CAP;
        else if (m_fill == FT) m_phase = P_FAULT;
      end
      P_CAP: begin
        m_count++;
        m_phase = P_CHECK;
      end
      P_CHECK: begin
        if (m_count == TGT) m_phase = P_DONE;
        else if (bus.stop)  m_phase = P_IDLE;
        else                m_phase = P_MOVE;
      end
      P_DONE: if (bus.box_ack) begin
        m_phase = P_IDLE;
        m_count = 0;
      end
      P_FAULT: if (bus.fault_clr) m_phase = P_IDLE;
      default: m_phase = P_IDLE;
    endcase
  endtask

  task automatic drive(input bit s, input bit st, input bit bp, input bit lf, input bit ba, input bit fc);
    bus.start          = s;
    bus.stop           = st;
    bus.bottle_present = bp;
    bus.level_full     = lf;
    bus.box_ack        = ba;
    bus.fault_clr      = fc;
  endtask

  task automatic cyc(input string tag);
    model_step();
    @(posedge clk);
    #1;
    chk({tag, "_outs"}, 32'(outs), 32'(exp_outs(m_phase)));
    chk({tag, "_count"}, 32'(bus.bottle_count), 32'(m_count));
  endtask

  task automatic one_bottle(input string tag);
    drive(1, 0, 0, 0, 0, 0); cyc({tag, "_start"});
    drive(0, 0, 1, 0, 0, 0); cyc({tag, "_fill"});
    drive(0, 0, 0, 1, 0, 0); cyc({tag, "_cap"});
    drive(0, 0, 0, 0, 0, 0); cyc({tag, "_check"});
    cyc({tag, "_after"});
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", 32'(outs), 32'd0);
    chk("reset_count", 32'(bus.bottle_count), 32'd0);
    rst_n = 1'b1;
    cyc("idle_hold");

    // full batch of TGT bottles with random conveyor gaps and fill lengths
    caps = 0;
    for (int b = 0; b < TGT; b++) begin
      drive(1, 0, 0, 0, 0, 0); cyc("batch_start");
      drive(0, 0, 0, 0, 0, 0);
      gap = $urandom_range(0, 2);
      repeat (gap) cyc("batch_move");
      drive(0, 0, 1, 0, 0, 0); cyc("batch_fill");
      len = $urandom_range(1, FT - 1);
      drive(0, 0, 0, 0, 0, 0);
      repeat (len - 1) cyc("batch_filling");
      drive(0, 0, 0, 1, 0, 0); cyc("batch_cap");
      if (bus.capper_go) caps++;
      drive(0, 0, 0, 0, 0, 0); cyc("batch_check");
      chk("batch_count_in_check", 32'(bus.bottle_count), 32'(b + 1));
      cyc("batch_exit_check");
    end
    chk("batch_capper_pulses", 32'(caps), 32'(TGT));
    chk("batch_done_flag", 32'(bus.batch_done), 32'd1);
    drive(1, 0, 1, 1, 0, 1);
    repeat ($urandom_range(1, 3)) cyc("done_hold");
    drive(0, 0, 0, 0, 1, 0); cyc("done_ack");
    chk("done_ack_count", 32'(bus.bottle_count), 32'd0);
    chk("done_ack_idle", 32'(outs), 32'd0);

    // fill timeout with one bottle already counted
    one_bottle("pre_to");
    drive(0, 0, 1, 0, 0, 0); cyc("to_fill");
    drive(0, 0, 0, 0, 0, 0);
    vcnt = 0;
    for (int i = 0; i < 20 && !bus.fault; i++) begin
      if (bus.valve_open) vcnt++;
      cyc("to_wait");
    end
    chk("timeout_valve_cycles", 32'(vcnt), 32'(FT));
    chk("timeout_fault", 32'(bus.fault), 32'd1);
    chk("timeout_count_kept", 32'(bus.bottle_count), 32'd1);
    drive(1, 1, 1, 1, 1, 0);
    repeat ($urandom_range(1, 3)) cyc("fault_hold");
    drive(0, 0, 0, 0, 0, 1); cyc("fault_clr");
    chk("fault_clr_idle", 32'(outs), 32'd0);

    // stop in MOVE
    drive(1, 0, 0, 0, 0, 0); cyc("stop_move_start");
    drive(1, 1, 0, 0, 0, 0); cyc("stop_move");
    chk("stop_move_idle", 32'(outs), 32'd0);

    // stop and bottle_present together in MOVE: valve never opens
    drive(1, 0, 0, 0, 0, 0); cyc("prio_start");
    valve_seen = 0;
    drive(0, 1, 1, 0, 0, 0); cyc("prio_both");
    if (bus.valve_open) valve_seen++;
    drive(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc("prio_idle");
      if (bus.valve_open) valve_seen++;
    end
    chk("prio_valve_never", 32'(valve_seen), 32'd0);

    // stop during FILL: bottle completes, IDLE after CHECK
    drive(1, 0, 0, 0, 0, 0); cyc("sfill_start");
    drive(0, 0, 1, 0, 0, 0); cyc("sfill_fill");
    drive(0, 1, 0, 0, 0, 0); cyc("sfill_stop1");
    chk("sfill_still_filling", 32'(bus.valve_open), 32'd1);
    drive(0, 1, 0, 1, 0, 0); cyc("sfill_cap");
    drive(0, 1, 0, 0, 0, 0); cyc("sfill_check");
    cyc("sfill_idle");
    chk("sfill_idle_outs", 32'(outs), 32'd0);
    chk("sfill_count", 32'(bus.bottle_count), 32'd2);

    // level_full arrives in the last allowed FILL cycle
    drive(1, 0, 0, 0, 0, 0); cyc("last_start");
    drive(0, 0, 1, 0, 0, 0); cyc("last_fill");
    drive(0, 0, 0, 0, 0, 0);
    repeat (FT - 1) cyc("last_filling");
    drive(0, 0, 0, 1, 0, 0); cyc("last_cap");
    chk("last_capper", 32'(bus.capper_go), 32'd1);
    chk("last_no_fault", 32'(bus.fault), 32'd0);
    drive(0, 0, 0, 0, 0, 0); cyc("last_check");
    cyc("last_done");
    chk("last_batch_done", 32'(bus.batch_done), 32'd1);
    drive(0, 0, 0, 0, 1, 0); cyc("last_ack");

    // reset asserted mid-FILL
    one_bottle("pre_rst");
    drive(0, 0, 1, 0, 0, 0); cyc("rst_fill");
    drive(0, 0, 0, 0, 0, 0); cyc("rst_filling");
    rst_n = 1'b0;
    #1;
    chk("rst_async_outs", 32'(outs), 32'd0);
    m_phase = P_IDLE;
    m_count = 0;
    m_fill  = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("rst_release");
    chk("rst_release_count", 32'(bus.bottle_count), 32'd0);

    // random soak against the model
    for (int i = 0; i < 800; i++) begin
      drive(($urandom_range(0, 1) == 1), ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      cyc("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
